// File: rtl/cpu_bus_responder.sv
// CPU bus slave: work RAM, PPU register window, PRG ROM port, open-bus latch
// and the $4014 OAM DMA engine that stalls the CPU while it copies a page.
module cpu_bus_responder #(
    parameter int RAM_AW = 11,
    parameter int PRG_AW = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_wdata,
    input  logic              cpu_rw_n,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_rdata_oe,
    output logic              cpu_halt,
    output logic [2:0]        ppu_reg,
    output logic [7:0]        ppu_wdata,
    output logic              ppu_we,
    output logic              ppu_re,
    input  logic [7:0]        ppu_rdata,
    output logic [7:0]        oam_wdata,
    output logic              oam_we,
    output logic [PRG_AW-1:0] prg_addr,
    input  logic [7:0]        prg_rdata
);

    // state  | meaning
    // IDLE   | CPU owns the bus, waiting for a $4014 write
    // ALIGN  | first dummy cycle after the trigger
    // ALIGN2 | extra dummy cycle when ALIGN fell on an odd cycle
    // RD     | read source byte {page, idx} through the normal decode
    // WR     | present latched byte to OAM, advance idx
    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ALIGN2,
        S_RD,
        S_WR
    } dma_state_t;

    localparam int RAM_DEPTH = 1 << RAM_AW;

    dma_state_t state, state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] dma_byte;
    logic [7:0] open_bus;
    logic       parity;
    logic       cpu_rd_q;

    logic [7:0] ram [RAM_DEPTH];

    logic [15:0]       bus_addr;
    logic [RAM_AW-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic [7:0]        rd_mux;
    logic              cpu_access;
    logic              cpu_rd;
    logic              cpu_wr;
    logic              sel_ram;
    logic              sel_ppu;
    logic              sel_prg;
    logic              dma_start;

    // While DMA owns the bus the CPU inputs are ignored entirely.
    assign cpu_access = (state == S_IDLE);
    assign bus_addr   = cpu_access ? cpu_addr : {page, idx};
    assign cpu_rd     = cpu_access & cpu_rw_n;
    assign cpu_wr     = cpu_access & ~cpu_rw_n;

    assign sel_ram   = (bus_addr[15:13] == 3'b000);
    assign sel_ppu   = (bus_addr[15:13] == 3'b001);
    assign sel_prg   = bus_addr[15];
    assign dma_start = cpu_wr & (bus_addr == 16'h4014);

    assign ram_addr  = bus_addr[RAM_AW-1:0];
    assign ram_rdata = ram[ram_addr];
    assign prg_addr  = bus_addr[PRG_AW-1:0];

    assign ppu_reg   = bus_addr[2:0];
    assign ppu_we    = cpu_wr & sel_ppu;
    assign ppu_re    = cpu_rd & sel_ppu;
    assign ppu_wdata = ppu_we ? cpu_wdata : 8'h00;

    assign cpu_halt     = ~cpu_access;
    assign cpu_rdata_oe = cpu_rd_q & ~cpu_halt;
    assign oam_we       = (state == S_WR);
    assign oam_wdata    = dma_byte;

    // DMA reads of the PPU page fall through to open bus.
    always_comb begin
        rd_mux = open_bus;
        if (sel_ram) begin
            rd_mux = ram_rdata;
        end else if (sel_prg) begin
            rd_mux = prg_rdata;
        end else if (sel_ppu && cpu_access) begin
            rd_mux = ppu_rdata;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (dma_start) state_nxt = S_ALIGN;
            S_ALIGN:  state_nxt = parity ? S_ALIGN2 : S_RD;
            S_ALIGN2: state_nxt = S_RD;
            S_RD:     state_nxt = S_WR;
            S_WR:     state_nxt = (idx == 8'hFF) ? S_IDLE : S_RD;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            page      <= 8'h00;
            idx       <= 8'h00;
            dma_byte  <= 8'h00;
            open_bus  <= 8'h00;
            parity    <= 1'b0;
            cpu_rd_q  <= 1'b0;
            cpu_rdata <= 8'h00;
        end else begin
            state    <= state_nxt;
            parity   <= ~parity;
            cpu_rd_q <= cpu_rd;
            if (cpu_rd) begin
                cpu_rdata <= rd_mux;
                open_bus  <= rd_mux;
            end
            if (cpu_wr) begin
                open_bus <= cpu_wdata;
            end
            if (dma_start) begin
                page <= cpu_wdata;
                idx  <= 8'h00;
            end
            if (state == S_RD) begin
                dma_byte <= rd_mux;
                open_bus <= rd_mux;
            end
            if (state == S_WR) begin
                idx <= idx + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cpu_wr && sel_ram) begin
            ram[ram_addr] <= cpu_wdata;
        end
    end

endmodule

// File: doc/cpu_bus_responder.md
# cpu_bus_responder

Slave side of the `cpu_6502` system bus. It decodes every CPU address and serves the access:
- 2 KB internal work RAM, mirrored.
- PPU register window, forwarded to the PPU as one-cycle strobes.
- PRG ROM read port.
- Open-bus latch for unmapped reads.

It also contains the OAM DMA engine at $4014, which stalls the CPU and copies one 256-byte page into PPU OAM.

## Interface
Parameters:
- RAM_AW, 11, work RAM address width (2 KB).
- PRG_AW, 15, PRG ROM address width (32 KB at $8000-$FFFF).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  data driven by CPU when cpu_rw_n=0.
- cpu_rw_n  in  1  1=read, 0=write.
- cpu_rdata  out  8  registered read data to CPU.
- cpu_rdata_oe  out  1  responder drives data bus (tristate enable at top level).
- cpu_halt  out  1  CPU stall request; CPU must hold PC and ignore the bus while high.
- ppu_reg  out  3  PPU register index (addr[2:0]).
- ppu_wdata  out  8  PPU write data.
- ppu_we  out  1  one-cycle PPU write strobe.
- ppu_re  out  1  one-cycle PPU read strobe.
- ppu_rdata  in  8  PPU read data, valid in the same cycle as ppu_re.
- oam_wdata  out  8  OAM byte from DMA.
- oam_we  out  1  one-cycle OAM write strobe (equivalent to a $2004 write).
- prg_addr  out  PRG_AW  PRG ROM address (combinational from the current bus address).
- prg_rdata  in  8  PRG ROM data, valid in the same cycle as prg_addr.

## Operation
Address map, decoded every cycle from cpu_addr, or from the DMA address while DMA is active:
- $0000-$1FFF: RAM at addr[10:0]; reads and writes.
- $2000-$3FFF: PPU register addr[2:0].
  - Read: ppu_re=1.
  - Write: ppu_we=1, ppu_wdata=cpu_wdata.
- $4014: write starts OAM DMA with page = cpu_wdata. A read returns open bus.
- $8000-$FFFF: PRG ROM at addr[14:0]; reads only, writes ignored.
- Everything else ($4000-$4013, $4015-$7FFF): reads return open bus; writes ignored.

Read path:
- cpu_rdata is registered: at the posedge ending a read cycle it loads the selected source.
- Open-bus latch: every completed read or write updates the latch with the bus data value. An unmapped read returns the latch.

Write path:
- RAM writes are committed at the posedge ending the write cycle.

Output enable:
- cpu_rdata_oe=1 in a cycle iff the previous cycle was a CPU read and the current cycle is not DMA-halted.

Cycle parity:
- A parity flop toggles every cycle from reset, starting at 0.

DMA state machine: IDLE -> ALIGN -> (ALIGN2) -> RD <-> WR -> IDLE.
- IDLE: a CPU write to $4014 latches page P and index i=0, then moves to ALIGN.
- ALIGN: one dummy cycle. Next state is ALIGN2 if parity=1 in this cycle, else RD.
- ALIGN2: one dummy cycle, then RD.
- RD: reads source address {P,i} through the normal decode (RAM, PRG or open bus) and latches the byte. ppu_re is never asserted by DMA. If P is $20-$3F the byte is open bus.
- WR: oam_wdata = latched byte, oam_we=1. i increments mod 256. Goes to RD if i != 255, else to IDLE.
- cpu_halt=1 in every state except IDLE.

## Timing
- Reset values: cpu_rdata=0, cpu_rdata_oe=0, cpu_halt=0, ppu_we=0, ppu_re=0, oam_we=0, oam_wdata=0, ppu_wdata=0, open-bus latch=0, parity=0, DMA state=IDLE, i=0.
  - RAM contents are not reset.
- Read latency: 1 clock. Data for the address in cycle N appears on cpu_rdata in cycle N+1.
- ppu_re/ppu_we: combinational in the access cycle, exactly one cycle per CPU access.
- DMA length: write to $4014 in cycle N sets cpu_halt from cycle N+1.
  - Halt lasts 513 cycles if parity=0 in cycle N+1, else 514.
  - cpu_halt falls in the cycle after the last WR.
- oam_we pulses: exactly 256, on every other cycle, with i = 0..255 in order.
- Reset mid-DMA (rst_n=0 at any posedge): DMA aborts to IDLE and cpu_halt=0 next cycle. No further oam_we.
- CPU bus inputs are ignored while cpu_halt=1, so a $4014 write cannot occur during DMA.
- Address boundaries: $07FF/$0800 alias; $1FFF maps to RAM $7FF; $3FFF maps to PPU reg 7; $7FFF is open bus; $8000 maps to prg_addr 0.

## Test plan
- RAM mirror: write $5A to $0123, read $0923 and $1923 -> cpu_rdata=$5A one cycle after each read; cpu_rdata_oe=1.
- PPU window: write $80 to $3FF8 -> ppu_we=1 for one cycle, ppu_reg=0, ppu_wdata=$80. Read $2002 with ppu_rdata=$C0 -> ppu_re for one cycle, cpu_rdata=$C0 next cycle.
- Open bus/ROM: read $FFFC with prg_rdata=$34 -> prg_addr=$7FFC, cpu_rdata=$34. Then read $5000 -> cpu_rdata=$34. Write $12 to $8000 -> ROM unchanged, no strobe.
- DMA even/odd: fill RAM $0200-$02FF with i^$A5 and write $02 to $4014, once with parity even and once odd -> cpu_halt high for 513 and 514 cycles respectively; 256 oam_we pulses with oam_wdata = i^$A5 in order.
- Reset mid-DMA: assert rst_n=0 after the 40th oam_we -> next cycle cpu_halt=0 and oam_we=0; a fresh $4014 write afterwards runs the full 256 transfers.
